dcf77_sync_controller: RTL and testbench
========================================

Name: dcf77_sync_controller

Overview:
- Consumes completed minute frames from the DCF77 pulse decoder, i.e. the frame_valid strobe plus the 59 decoded bits.
- Validates each frame, decodes the BCD time and date, and runs a sync state machine (UNSYNC/CAND/SYNC/HOLD).
- Keeps a free-running local time that is re-aligned on every accepted frame.
- Sits between the decoder and the SpartanMC peripheral register interface, and supplies pps and time to the logging datapath.

Parameters:
CLOCK_FREQUENCY, 16000000, clk frequency in Hz; the prescaler counts 0..CLOCK_FREQUENCY-1.
MISS_LIMIT, 2, minute rollovers without an accepted frame before SYNC->HOLD or CAND->UNSYNC.
HOLDOVER_MIN, 60, minutes spent in HOLD before HOLD->UNSYNC.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle strobe; frame is stable while it is high
frame  in  59  frame[k] = DCF77 bit of second k
pps  out  1  one-cycle pulse at each local second start
sec_bcd  out  7  seconds, BCD 00-59
min_bcd  out  7  minutes, BCD 00-59
hour_bcd  out  6  hours, BCD 00-23
day_bcd  out  6  day of month, last decoded value
wday  out  3  day of week 1-7, last decoded value
month_bcd  out  5  month, last decoded value
year_bcd  out  8  year 00-99, last decoded value
cest  out  1  frame[17] of last accepted frame
date_stale  out  1  local midnight has passed since the last accepted frame
sync_state  out  2  0=UNSYNC 1=CAND 2=SYNC 3=HOLD
time_valid  out  1  high in SYNC or HOLD
err_count  out  8  rejected plus inconsistent frames, saturates at 255

Behaviour:
- Reset (async): every output 0; state UNSYNC; prescaler, miss counter, hold counter and candidate registers all 0.
- Frame check (combinational on the frame_valid cycle):
  - Structure: frame[0]=0, frame[20]=1, frame[17]^frame[18]=1.
  - Even parity over frame[28:21], frame[35:29] and frame[58:36].
  - BCD digits each <=9; minute <=59, hour <=23, day 1-31, wday 1-7, month 1-12.
  - Any failure marks the frame invalid.
- Latency: all effects of a frame are visible on the cycle after frame_valid.
- Prescaler:
  - At terminal count it wraps, pulses pps and increments sec in BCD.
  - sec 59->00 increments min; min 59->00 increments hour; hour 23->00 sets date_stale.
  - Every sec 59->00 rollover increments miss_cnt (saturating).
  - The prescaler runs in every state.
- Expected minute-of-day at frame arrival = running hh:mm + 1 minute if sec_bcd>=0x30, else running hh:mm (tolerates edge jitter either side of the rollover).
- Load action:
  - Copy hour, minute, date and cest from the frame.
  - sec=0, prescaler=0, pps=1 that cycle; miss_cnt=0, hold_cnt=0, date_stale=0.
  - A prescaler terminal count in the same cycle is suppressed, so only one pps is issued.
- UNSYNC:
  - Valid frame -> CAND; capture cand_hhmm.
  - Invalid frame -> err_count+1.
- CAND:
  - Valid frame with hh:mm == cand_hhmm+1 minute (mod 24 h) -> SYNC, load.
  - Other valid frame -> stay CAND, recapture cand_hhmm, err_count+1.
  - Invalid frame -> UNSYNC, err_count+1.
  - miss_cnt reaching MISS_LIMIT -> UNSYNC.
- SYNC:
  - Valid frame consistent with the expected minute -> load, stay SYNC.
  - Valid but inconsistent frame -> HOLD, err_count+1, no load.
  - Invalid frame -> err_count+1, stay SYNC.
  - miss_cnt reaching MISS_LIMIT -> HOLD.
- HOLD:
  - Time keeps free-running.
  - hold_cnt increments on each minute rollover.
  - Consistent valid frame -> SYNC, load.
  - Inconsistent valid frame -> CAND, capture cand_hhmm, err_count+1.
  - Invalid frame -> err_count+1.
  - hold_cnt reaching HOLDOVER_MIN -> UNSYNC.
- Time registers load only in the SYNC entry/stay paths. UNSYNC and CAND never overwrite the time, and time_valid stays low in those states.
- Simultaneous events: a frame event takes priority over any miss or hold limit reached in the same cycle.
- Reset mid-frame discards everything; no partial state survives.

Test Plan:
1. Valid frames 12:34 then 12:35 (CET, 2024-05-17, wday 5), CLOCK_FREQUENCY=100 -> after frame 1 sync_state=1; after frame 2 sync_state=2, time_valid=1, hour_bcd=0x12, min_bcd=0x35, sec_bcd=0, one pps.
2. Flip frame[28] on the second frame -> sync_state=0, err_count=1, time outputs unchanged.
3. Synced, then 61 s with no frames -> sec wraps 59->00, min_bcd=0x36, pps every 100 clocks; the second rollover with MISS_LIMIT=2 gives sync_state=3, time_valid=1.
4. HOLD with HOLDOVER_MIN=2, no frames for 2 further minutes -> sync_state=0, time_valid=0.
5. Synced at 23:59:59, frame 00:00 arrives in the prescaler terminal cycle -> exactly one pps, hour_bcd=0, min_bcd=0, date_stale=0, stays SYNC.
6. Assert reset during SYNC with sec_bcd=0x20 -> all outputs 0, sync_state=0 asynchronously; the next valid frame leads only to CAND.

Source files
------------

// File: rtl/dcf77_sync_controller.sv
// DCF77 minute-frame validation, BCD time/date decode, sync state
// machine (UNSYNC/CAND/SYNC/HOLD) and free-running local time.
module dcf77_sync_controller #(
  parameter int CLOCK_FREQUENCY = 16000000,
  parameter int MISS_LIMIT      = 2,
  parameter int HOLDOVER_MIN    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [58:0] frame,
  output logic        pps,
  output logic [6:0]  sec_bcd,
  output logic [6:0]  min_bcd,
  output logic [5:0]  hour_bcd,
  output logic [5:0]  day_bcd,
  output logic [2:0]  wday,
  output logic [4:0]  month_bcd,
  output logic [7:0]  year_bcd,
  output logic        cest,
  output logic        date_stale,
  output logic [1:0]  sync_state,
  output logic        time_valid,
  output logic [7:0]  err_count
);

  localparam int PW =
    (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [PW-1:0] PRESC_TC =
    PW'(CLOCK_FREQUENCY - 1);
  localparam logic [7:0]  MISS_LIM = 8'(MISS_LIMIT);
  localparam logic [15:0] HOLD_LIM = 16'(HOLDOVER_MIN);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_CAND   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // BCD 00..59 increment with wrap
  function automatic logic [6:0] inc60(input logic [6:0] v);
    logic [6:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (v[6:4] == 3'd5) ? 3'd0 : v[6:4] + 3'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // BCD 00..23 increment with wrap
  function automatic logic [5:0] inc24(input logic [5:0] v);
    logic [5:0] r;
    r = v;
    if (v == 6'h23) begin
      r = 6'h00;
    end else if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[5:4] = v[5:4] + 2'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // {hour, minute} plus one minute, modulo 24 h
  function automatic logic [12:0] inc_hhmm(input logic [12:0] t);
    logic [12:0] r;
    r[6:0]  = inc60(t[6:0]);
    r[12:7] = (t[6:0] == 7'h59) ? inc24(t[12:7]) : t[12:7];
    return r;
  endfunction

  state_t state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    day_q, day_d;
  logic [2:0]    wday_q, wday_d;
  logic [4:0]    month_q, month_d;
  logic [7:0]    year_q, year_d;
  logic          cest_q, cest_d;
  logic          stale_q, stale_d;
  logic          pps_q, pps_d;
  logic [7:0]    miss_q, miss_d;
  logic [15:0]   hold_q, hold_d;
  logic [12:0]   cand_q, cand_d;
  logic [7:0]    err_q, err_d;

  logic [3:0] f_min_lo;
  logic [2:0] f_min_hi;
  logic [3:0] f_hour_lo;
  logic [1:0] f_hour_hi;
  logic [3:0] f_day_lo;
  logic [1:0] f_day_hi;
  logic [2:0] f_wday;
  logic [3:0] f_mon_lo;
  logic       f_mon_hi;
  logic [7:0] f_year;

  assign f_min_lo  = frame[24:21];
  assign f_min_hi  = frame[27:25];
  assign f_hour_lo = frame[32:29];
  assign f_hour_hi = frame[34:33];
  assign f_day_lo  = frame[39:36];
  assign f_day_hi  = frame[41:40];
  assign f_wday    = frame[44:42];
  assign f_mon_lo  = frame[48:45];
  assign f_mon_hi  = frame[49];
  assign f_year    = frame[57:50];

  logic unused_frame_bits;
  assign unused_frame_bits = ^{frame[19], frame[16:1]};

  logic struct_ok, parity_ok, digit_ok, range_ok;
  logic frame_ok;

  // Structure, parity and BCD range checks on the presented frame
  always_comb begin
    struct_ok = ~frame[0] & frame[20]
              & (frame[17] ^ frame[18]);
    parity_ok = ~(^frame[28:21])
              & ~(^frame[35:29])
              & ~(^frame[58:36]);
    digit_ok  = (f_min_lo <= 4'd9)
              & (f_hour_lo <= 4'd9)
              & (f_day_lo <= 4'd9)
              & (f_mon_lo <= 4'd9)
              & (f_year[3:0] <= 4'd9)
              & (f_year[7:4] <= 4'd9);
    range_ok  = (f_min_hi <= 3'd5)
              & ((f_hour_hi < 2'd2)
                 | ((f_hour_hi == 2'd2) & (f_hour_lo <= 4'd3)))
              & ({f_day_hi, f_day_lo} != 6'd0)
              & ((f_day_hi < 2'd3) | (f_day_lo <= 4'd1))
              & (f_wday != 3'd0)
              & (f_mon_hi ? (f_mon_lo <= 4'd2)
                          : (f_mon_lo != 4'd0));
    frame_ok  = struct_ok & parity_ok & digit_ok & range_ok;
  end

  logic        fv_good, fv_bad;
  logic [12:0] f_hhmm, exp_hhmm, cand_next;
  logic        consistent, cand_match;
  logic        tc;

  assign fv_good    = frame_valid & frame_ok;
  assign fv_bad     = frame_valid & ~frame_ok;
  assign f_hhmm     = {frame[34:29], frame[27:21]};
  assign exp_hhmm   = (sec_q >= 7'h30)
                    ? inc_hhmm({hour_q, min_q})
                    : {hour_q, min_q};
  assign cand_next  = inc_hhmm(cand_q);
  assign consistent = (f_hhmm == exp_hhmm);
  assign cand_match = (f_hhmm == cand_next);
  assign tc         = (presc_q == PRESC_TC);

  logic load, capture, err_inc;

  // Sync FSM: frame events win over miss/hold limits
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      ST_UNSYNC: begin
        if (fv_good) begin
          state_d = ST_CAND;
          capture = 1'b1;
        end else if (fv_bad) begin
          err_inc = 1'b1;
        end
      end
      ST_CAND: begin
        if (fv_good && cand_match) begin
          state_d = ST_SYNC;
          load    = 1'b1;
        end else if (fv_good) begin
          capture = 1'b1;
          err_inc = 1'b1;
        end else if (fv_bad) begin
          state_d = ST_UNSYNC;
          err_inc = 1'b1;
        end else if (miss_q >= MISS_LIM) begin
          state_d = ST_UNSYNC;
        end
      end
      ST_SYNC: begin
        if (fv_good && consistent) begin
          load = 1'b1;
        end else if (fv_good) begin
          state_d = ST_HOLD;
          err_inc = 1'b1;
        end else if (fv_bad) begin
          err_inc = 1'b1;
        end else if (miss_q >= MISS_LIM) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fv_good && consistent) begin
          state_d = ST_SYNC;
          load    = 1'b1;
        end else if (fv_good) begin
          state_d = ST_CAND;
          capture = 1'b1;
          err_inc = 1'b1;
        end else if (fv_bad) begin
          err_inc = 1'b1;
        end else if (hold_q >= HOLD_LIM) begin
          state_d = ST_UNSYNC;
        end
      end
    endcase
  end

  // Local time tick, then frame load/capture overrides
  always_comb begin
    presc_d = presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    wday_d  = wday_q;
    month_d = month_q;
    year_d  = year_q;
    cest_d  = cest_q;
    stale_d = stale_q;
    pps_d   = 1'b0;
    miss_d  = miss_q;
    hold_d  = hold_q;
    cand_d  = cand_q;
    err_d   = err_q;
    if (tc) begin
      presc_d = '0;
      pps_d   = 1'b1;
      sec_d   = inc60(sec_q);
      if (sec_q == 7'h59) begin
        min_d = inc60(min_q);
        if (miss_q != 8'hff) begin
          miss_d = miss_q + 8'd1;
        end
        if (state_q == ST_HOLD && hold_q != 16'hffff) begin
          hold_d = hold_q + 16'd1;
        end
        if (min_q == 7'h59) begin
          hour_d = inc24(hour_q);
          if (hour_q == 6'h23) begin
            stale_d = 1'b1;
          end
        end
      end
    end
    if (capture) begin
      cand_d = f_hhmm;
      miss_d = '0;
    end
    if (load) begin
      presc_d = '0;
      pps_d   = 1'b1;
      sec_d   = '0;
      min_d   = frame[27:21];
      hour_d  = frame[34:29];
      day_d   = frame[41:36];
      wday_d  = f_wday;
      month_d = frame[49:45];
      year_d  = f_year;
      cest_d  = frame[17];
      stale_d = 1'b0;
      miss_d  = '0;
      hold_d  = '0;
    end
    if (err_inc && err_q != 8'hff) begin
      err_d = err_q + 8'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= '0;
      wday_q  <= '0;
      month_q <= '0;
      year_q  <= '0;
      cest_q  <= 1'b0;
      stale_q <= 1'b0;
      pps_q   <= 1'b0;
      miss_q  <= '0;
      hold_q  <= '0;
      cand_q  <= '0;
      err_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      wday_q  <= wday_d;
      month_q <= month_d;
      year_q  <= year_d;
      cest_q  <= cest_d;
      stale_q <= stale_d;
      pps_q   <= pps_d;
      miss_q  <= miss_d;
      hold_q  <= hold_d;
      cand_q  <= cand_d;
      err_q   <= err_d;
    end
  end

  assign pps        = pps_q;
  assign sec_bcd    = sec_q;
  assign min_bcd    = min_q;
  assign hour_bcd   = hour_q;
  assign day_bcd    = day_q;
  assign wday       = wday_q;
  assign month_bcd  = month_q;
  assign year_bcd   = year_q;
  assign cest       = cest_q;
  assign date_stale = stale_q;
  assign sync_state = state_q;
  assign time_valid = (state_q == ST_SYNC)
                    | (state_q == ST_HOLD);
  assign err_count  = err_q;

endmodule

// File: tb/tb_dcf77_sync_controller.sv
// Bench for dcf77_sync_controller: directed and random frames
// against an integer seconds-of-day reference model.
module tb_dcf77_sync_controller;

  localparam int CF    = 100;
  localparam int MISS  = 2;
  localparam int HOLDM = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic [58:0] frame;
  logic        pps;
  logic [6:0]  sec_bcd;
  logic [6:0]  min_bcd;
  logic [5:0]  hour_bcd;
  logic [5:0]  day_bcd;
  logic [2:0]  wday;
  logic [4:0]  month_bcd;
  logic [7:0]  year_bcd;
  logic        cest;
  logic        date_stale;
  logic [1:0]  sync_state;
  logic        time_valid;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  int m_presc, m_sod, m_state, m_miss, m_hold;
  int m_err, m_cand, m_day, m_wday, m_mon, m_year;
  bit m_cest, m_stale, m_pps;
  int d_min, d_hour, d_day, d_wday, d_mon, d_year;
  bit d_cest;

  dcf77_sync_controller #(
    .CLOCK_FREQUENCY(CF),
    .MISS_LIMIT(MISS),
    .HOLDOVER_MIN(HOLDM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_valid(frame_valid),
    .frame(frame),
    .pps(pps),
    .sec_bcd(sec_bcd),
    .min_bcd(min_bcd),
    .hour_bcd(hour_bcd),
    .day_bcd(day_bcd),
    .wday(wday),
    .month_bcd(month_bcd),
    .year_bcd(year_bcd),
    .cest(cest),
    .date_stale(date_stale),
    .sync_state(sync_state),
    .time_valid(time_valid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int n);
    return (n / 10) * 16 + (n % 10);
  endfunction

  function automatic int bits(input logic [58:0] f,
                              input int lo, input int n);
    int v;
    v = 0;
    for (int i = 0; i < n; i++)
      if (f[lo+i]) v += (1 << i);
    return v;
  endfunction

  function automatic int ones(input logic [58:0] f,
                              input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++)
      if (f[i]) c++;
    return c;
  endfunction

  function automatic logic [58:0] put(input logic [58:0] f,
                                     input int lo, input int n,
                                     input int v);
    logic [58:0] r;
    r = f;
    for (int i = 0; i < n; i++)
      r[lo+i] = ((v >> i) & 1) != 0;
    return r;
  endfunction

  function automatic logic [58:0] mk(input int mi, input int hr,
                                     input int dy, input int wd,
                                     input int mo, input int yr,
                                     input bit cs);
    logic [58:0] f;
    f = '0;
    f[20] = 1'b1;
    f[17] = cs;
    f[18] = ~cs;
    f = put(f, 21, 7, to_bcd(mi));
    f = put(f, 29, 6, to_bcd(hr));
    f = put(f, 36, 6, to_bcd(dy));
    f = put(f, 42, 3, wd);
    f = put(f, 45, 5, to_bcd(mo));
    f = put(f, 50, 8, to_bcd(yr));
    f[28] = (ones(f, 21, 27) % 2) != 0;
    f[35] = (ones(f, 29, 34) % 2) != 0;
    f[58] = (ones(f, 36, 57) % 2) != 0;
    return f;
  endfunction

  // decode into d_* and judge the frame by the DCF77 rules
  function automatic bit decode(input logic [58:0] f);
    bit ok;
    int mlo, mhi, hlo, hhi, dlo, dhi, olo, ohi, ylo, yhi;
    mlo = bits(f, 21, 4); mhi = bits(f, 25, 3);
    hlo = bits(f, 29, 4); hhi = bits(f, 33, 2);
    dlo = bits(f, 36, 4); dhi = bits(f, 40, 2);
    olo = bits(f, 45, 4); ohi = bits(f, 49, 1);
    ylo = bits(f, 50, 4); yhi = bits(f, 54, 4);
    d_min  = mhi * 10 + mlo;
    d_hour = hhi * 10 + hlo;
    d_day  = dhi * 10 + dlo;
    d_wday = bits(f, 42, 3);
    d_mon  = ohi * 10 + olo;
    d_year = yhi * 10 + ylo;
    d_cest = f[17];
    ok = (f[0] == 1'b0) && (f[20] == 1'b1) && (f[17] != f[18]);
    ok = ok && (ones(f, 21, 28) % 2 == 0);
    ok = ok && (ones(f, 29, 35) % 2 == 0);
    ok = ok && (ones(f, 36, 58) % 2 == 0);
    ok = ok && mlo <= 9 && hlo <= 9 && dlo <= 9;
    ok = ok && olo <= 9 && ylo <= 9 && yhi <= 9;
    ok = ok && d_min <= 59 && d_hour <= 23;
    ok = ok && d_day >= 1 && d_day <= 31;
    ok = ok && d_wday >= 1 && d_wday <= 7;
    ok = ok && d_mon >= 1 && d_mon <= 12;
    return ok;
  endfunction

  function automatic int exp_minute();
    int e;
    e = m_sod / 60;
    if (m_sod % 60 >= 30) e = e + 1;
    return e % 1440;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_sod = 0; m_state = 0; m_miss = 0;
    m_hold = 0; m_err = 0; m_cand = 0; m_day = 0;
    m_wday = 0; m_mon = 0; m_year = 0;
    m_cest = 0; m_stale = 0; m_pps = 0;
  endtask

  // reference behaviour for one clock edge
  task automatic model_edge(input bit fv, input logic [58:0] f);
    bit ok, ld, cap, er;
    int fm, em, nst;
    ok = decode(f);
    fm = d_hour * 60 + d_min;
    em = exp_minute();
    ld = 0; cap = 0; er = 0;
    nst = m_state;
    if (fv) begin
      case (m_state)
        0: begin
          if (ok) begin nst = 1; cap = 1; end
          else er = 1;
        end
        1: begin
          if (!ok) begin nst = 0; er = 1; end
          else if (fm == (m_cand + 1) % 1440) begin
            nst = 2; ld = 1;
          end else begin cap = 1; er = 1; end
        end
        2: begin
          if (!ok) er = 1;
          else if (fm == em) ld = 1;
          else begin nst = 3; er = 1; end
        end
        default: begin
          if (!ok) er = 1;
          else if (fm == em) begin nst = 2; ld = 1; end
          else begin nst = 1; cap = 1; er = 1; end
        end
      endcase
    end else begin
      if (m_state == 1 && m_miss >= MISS) nst = 0;
      if (m_state == 2 && m_miss >= MISS) nst = 3;
      if (m_state == 3 && m_hold >= HOLDM) nst = 0;
    end
    m_pps = 0;
    if (ld) begin
      m_sod = fm * 60; m_presc = 0; m_pps = 1;
      m_miss = 0; m_hold = 0; m_stale = 0;
      m_day = d_day; m_wday = d_wday; m_mon = d_mon;
      m_year = d_year; m_cest = d_cest;
    end else if (m_presc == CF - 1) begin
      m_presc = 0; m_pps = 1;
      m_sod = m_sod + 1;
      if (m_sod % 60 == 0) begin
        if (m_miss < 255) m_miss++;
        if (m_state == 3 && m_hold < 65535) m_hold++;
      end
      if (m_sod == 86400) begin
        m_sod = 0; m_stale = 1;
      end
    end else begin
      m_presc++;
    end
    if (cap) begin m_cand = fm; m_miss = 0; end
    if (er && m_err < 255) m_err++;
    m_state = nst;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".pps"},   32'(pps),        32'(m_pps));
    chk({t, ".sec"},   32'(sec_bcd),    to_bcd(m_sod % 60));
    chk({t, ".min"},   32'(min_bcd),    to_bcd((m_sod / 60) % 60));
    chk({t, ".hour"},  32'(hour_bcd),   to_bcd(m_sod / 3600));
    chk({t, ".day"},   32'(day_bcd),    to_bcd(m_day));
    chk({t, ".wday"},  32'(wday),       m_wday);
    chk({t, ".month"}, 32'(month_bcd),  to_bcd(m_mon));
    chk({t, ".year"},  32'(year_bcd),   to_bcd(m_year));
    chk({t, ".cest"},  32'(cest),       32'(m_cest));
    chk({t, ".stale"}, 32'(date_stale), 32'(m_stale));
    chk({t, ".state"}, 32'(sync_state), m_state);
    chk({t, ".tv"},    32'(time_valid), 32'(m_state >= 2));
    chk({t, ".err"},   32'(err_count),  m_err);
  endtask

  task automatic step(input bit fv, input logic [58:0] f);
    frame_valid = fv;
    frame = f;
    model_edge(fv, f);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  task automatic run(input int n, input string t);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0);
      check_all(t);
    end
  endtask

  initial begin
    logic [58:0] fr;
    int r, n, em, bi;
    reset = 1'b1;
    frame_valid = 1'b0;
    frame = '0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // bad parity on the confirming frame
    step(1'b1, mk(34, 12, 17, 5, 5, 24, 1'b0));
    check_all("t2_f1");
    fr = mk(35, 12, 17, 5, 5, 24, 1'b0);
    fr[28] = ~fr[28];
    step(1'b1, fr);
    check_all("t2_f2");
    chk("t2_state", 32'(sync_state), 0);
    chk("t2_err", 32'(err_count), 1);
    chk("t2_hour", 32'(hour_bcd), 0);

    // two consecutive valid minutes reach SYNC
    step(1'b1, mk(34, 12, 17, 5, 5, 24, 1'b0));
    check_all("t1_f1");
    chk("t1_cand", 32'(sync_state), 1);
    step(1'b1, mk(35, 12, 17, 5, 5, 24, 1'b0));
    check_all("t1_f2");
    chk("t1_sync", 32'(sync_state), 2);
    chk("t1_hour", 32'(hour_bcd), 32'h12);
    chk("t1_min", 32'(min_bcd), 32'h35);
    chk("t1_pps", 32'(pps), 1);
    chk("t1_year", 32'(year_bcd), 32'h24);

    // free-run, miss limit, holdover expiry
    run(6100, "t3a");
    chk("t3_min", 32'(min_bcd), 32'h36);
    chk("t3_sec", 32'(sec_bcd), 32'h01);
    chk("t3_sync", 32'(sync_state), 2);
    run(6000, "t3b");
    chk("t3_hold", 32'(sync_state), 3);
    chk("t3_tv", 32'(time_valid), 1);
    run(12000, "t4");
    chk("t4_unsync", 32'(sync_state), 0);
    chk("t4_tv", 32'(time_valid), 0);

    // midnight frame on the prescaler terminal cycle
    step(1'b1, mk(58, 23, 17, 5, 5, 24, 1'b0));
    check_all("t5_f1");
    step(1'b1, mk(59, 23, 17, 5, 5, 24, 1'b0));
    check_all("t5_f2");
    run(5999, "t5_run");
    chk("t5_pre_sec", 32'(sec_bcd), 32'h59);
    step(1'b1, mk(0, 0, 18, 6, 5, 24, 1'b0));
    check_all("t5_f3");
    chk("t5_pps", 32'(pps), 1);
    chk("t5_hour", 32'(hour_bcd), 0);
    chk("t5_min", 32'(min_bcd), 0);
    chk("t5_stale", 32'(date_stale), 0);
    chk("t5_sync", 32'(sync_state), 2);
    run(99, "t5_post");

    // asynchronous reset in SYNC
    run(2000 - 99, "t6_run");
    chk("t6_sec", 32'(sec_bcd), 32'h20);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, mk(58, 23, 3, 2, 12, 25, 1'b1));
    check_all("t6_f1");
    chk("t6_cand", 32'(sync_state), 1);

    // local midnight without a frame sets date_stale
    step(1'b1, mk(59, 23, 3, 2, 12, 25, 1'b1));
    check_all("t7_f1");
    run(6000, "t7_run");
    chk("t7_stale", 32'(date_stale), 1);
    chk("t7_hour", 32'(hour_bcd), 0);

    // randomized frames and gaps
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: begin
          em = exp_minute();
          fr = mk(em % 60, em / 60, $urandom_range(1, 31),
                  $urandom_range(1, 7), $urandom_range(1, 12),
                  $urandom_range(0, 99), 1'($urandom_range(0, 1)));
        end
        1: begin
          em = (m_cand + 1) % 1440;
          fr = mk(em % 60, em / 60, $urandom_range(1, 31),
                  $urandom_range(1, 7), $urandom_range(1, 12),
                  $urandom_range(0, 99), 1'($urandom_range(0, 1)));
        end
        2, 3: begin
          fr = mk($urandom_range(0, 59), $urandom_range(0, 23),
                  $urandom_range(1, 31), $urandom_range(1, 7),
                  $urandom_range(1, 12), $urandom_range(0, 99),
                  1'($urandom_range(0, 1)));
          if (r == 3) begin
            bi = $urandom_range(0, 58);
            fr[bi] = ~fr[bi];
          end
        end
        default: fr = '0;
      endcase
      if (r <= 3) begin
        step(1'b1, fr);
        check_all("rnd_frame");
      end else begin
        n = (r == 6) ? $urandom_range(1000, 4000)
                     : $urandom_range(1, 200);
        run(n, "rnd_idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
